// File: rtl/mp_link_ctrl.sv
// Multiplayer UART link sequencer: ready handshake, loss notification and peer-loss detection.
// Drives single-cycle, flow-controlled strobes into the UART FIFO wrapper.
module mp_link_ctrl #(
   parameter int unsigned READY_PERIOD = 100000,
   parameter int unsigned LOSS_REPEAT  = 4,
   parameter logic [7:0]  CHAR_READY   = 8'h52,
   parameter logic [7:0]  CHAR_LOSS    = 8'h4C
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       multiplayer,
   input  logic       player_ready,
   input  logic       game_over,
   input  logic       tx_full,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       wr_uart,
   output logic [7:0] w_data,
   output logic       rd_uart,
   output logic       game_start,
   output logic       peer_lost,
   output logic [2:0] link_state
);

   localparam int unsigned PER_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
   localparam int unsigned REP_W = (LOSS_REPEAT > 1) ? $clog2(LOSS_REPEAT) : 1;
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(READY_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(LOSS_REPEAT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_PEER = 3'd1,
      S_SYNC      = 3'd2,
      S_PLAYING   = 3'd3,
      S_LOST_TX   = 3'd4,
      S_WON       = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t           state;
   logic [PER_W-1:0] per_cnt;
   logic [REP_W-1:0] rep_cnt;
   logic             tx_pend;
   logic [7:0]       tx_char;

   logic wait_abort;
   logic tx_fire;
   logic rx_valid;
   logic rx_ready;
   logic rx_loss;

   // A popped byte is consumed on the edge that closes its rd_uart cycle (FWFT head still valid).
   always_comb begin
      wait_abort = (state == S_WAIT_PEER) && !player_ready;
      tx_fire    = tx_pend && !tx_full && !wait_abort;
      rx_valid   = rd_uart && (state != S_IDLE);
      rx_ready   = rx_valid && (r_data == CHAR_READY);
      rx_loss    = rx_valid && (r_data == CHAR_LOSS);
      link_state = state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wr_uart    <= 1'b0;
         w_data     <= '0;
         rd_uart    <= 1'b0;
         game_start <= 1'b0;
         peer_lost  <= 1'b0;
         per_cnt    <= '0;
         rep_cnt    <= '0;
         tx_pend    <= 1'b0;
         tx_char    <= '0;
      end else if (!multiplayer) begin
         state      <= S_IDLE;
         wr_uart    <= 1'b0;
         rd_uart    <= 1'b0;
         game_start <= 1'b0;
         peer_lost  <= 1'b0;
         per_cnt    <= '0;
         rep_cnt    <= '0;
         tx_pend    <= 1'b0;
      end else begin
         wr_uart    <= 1'b0;
         game_start <= 1'b0;
         rd_uart    <= (state != S_IDLE) && !rx_empty && !rd_uart;
         if (tx_fire) begin
            wr_uart <= 1'b1;
            w_data  <= tx_char;
            tx_pend <= 1'b0;
         end
         // Later assignments below override the defaults above (e.g. re-arming tx_pend).
         case (state)
            S_IDLE: begin
               peer_lost <= 1'b0;
               per_cnt   <= '0;
               rep_cnt   <= '0;
               tx_pend   <= 1'b0;
               if (player_ready) begin
                  state   <= S_WAIT_PEER;
                  tx_pend <= 1'b1;
                  tx_char <= CHAR_READY;
               end
            end
            S_WAIT_PEER: begin
               if (!player_ready) begin
                  state   <= S_IDLE;
                  tx_pend <= 1'b0;
                  rd_uart <= 1'b0;
               end else if (rx_ready) begin
                  state   <= S_SYNC;
                  tx_pend <= 1'b1;
                  tx_char <= CHAR_READY;
               end else if (per_cnt == PER_LAST) begin
                  per_cnt <= '0;
                  tx_pend <= 1'b1;
               end else begin
                  per_cnt <= per_cnt + 1'b1;
               end
            end
            S_SYNC: begin
               // wr_uart high with nothing pending means the sync 'R' has just gone out.
               if (wr_uart && !tx_pend) begin
                  game_start <= 1'b1;
                  state      <= S_PLAYING;
               end
            end
            S_PLAYING: begin
               if (rx_loss) begin
                  peer_lost <= 1'b1;
                  state     <= S_WON;
               end else if (game_over) begin
                  state   <= S_LOST_TX;
                  rep_cnt <= '0;
                  tx_pend <= 1'b1;
                  tx_char <= CHAR_LOSS;
               end
            end
            S_LOST_TX: begin
               if (tx_fire) begin
                  if (rep_cnt == REP_LAST) begin
                     state <= S_DONE;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                     tx_pend <= 1'b1;
                  end
               end
            end
            S_WON: begin
               peer_lost <= 1'b1;
               if (game_over) state <= S_DONE;
            end
            S_DONE: begin
               if (!player_ready && !game_over) begin
                  state     <= S_IDLE;
                  peer_lost <= 1'b0;
                  rd_uart   <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               tx_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule
